// File: rtl/boton_pulso_repeticion.sv
// Button conditioner for the hour/minute counters: synchronizes, debounces and
// turns the up/down buttons into 1-cycle pulses with auto-repeat while held.

module boton_canal #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic inhibit,
    output logic level,
    output logic level_next,
    output logic pulse
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    logic             s1;
    logic             s2;
    logic             level_prev;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_next;
    logic [CNT_W-1:0] timer;
    state_t           state;

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        level_next   = level;
        deb_cnt_next = '0;
        if (s2 != level) begin
            if (deb_cnt >= DEB_LAST) begin
                level_next = ~level;
            end else begin
                deb_cnt_next = deb_cnt + 1'b1;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            level      <= 1'b0;
            level_prev <= 1'b0;
            deb_cnt    <= '0;
            timer      <= '0;
            state      <= IDLE;
            pulse      <= 1'b0;
        end else begin
            s1         <= raw;
            s2         <= s1;
            level      <= level_next;
            deb_cnt    <= deb_cnt_next;
            level_prev <= level;
            pulse      <= 1'b0;
            timer      <= (timer == CNT_MAX) ? timer : timer + 1'b1;

            // Prev level keeps tracking while inhibited, so a release of the other
            // button can never look like a fresh press of this one.
            if (!level || inhibit) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!level_prev) begin
                            pulse <= 1'b1;
                            state <= HOLD;
                            timer <= '0;
                        end
                    end
                    HOLD: begin
                        if (timer >= HOLD_LAST) begin
                            pulse <= 1'b1;
                            state <= REPEAT;
                            timer <= '0;
                        end
                    end
                    REPEAT: begin
                        if (timer >= REP_LAST) begin
                            pulse <= 1'b1;
                            timer <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module boton_pulso_repeticion #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 20_000_000,
    parameter int CNT_W           = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up_raw,
    input  logic btn_down_raw,
    output logic aumento,
    output logic disminuye,
    output logic up_level,
    output logic down_level
);
    logic up_next;
    logic down_next;
    logic inhibit;

    // Inhibit looks at the levels about to be registered, so no pulse can be
    // launched into a cycle where both debounced levels are 1.
    assign inhibit = up_next & down_next;

    boton_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_up (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_up_raw),
        .inhibit   (inhibit),
        .level     (up_level),
        .level_next(up_next),
        .pulse     (aumento)
    );

    boton_canal #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_down (
        .clk       (clk),
        .rst       (rst),
        .raw       (btn_down_raw),
        .inhibit   (inhibit),
        .level     (down_level),
        .level_next(down_next),
        .pulse     (disminuye)
    );
endmodule

// File: tb/tb_boton_pulso_repeticion.sv
// Directed bench for boton_pulso_repeticion with short debounce/hold/repeat
// settings; pulse edge indices are recorded and compared to hand-computed ones.

module tb_boton_pulso_repeticion;
    logic clk = 1'b0;
    logic rst;
    logic btn_up_raw;
    logic btn_down_raw;
    logic aumento;
    logic disminuye;
    logic up_level;
    logic down_level;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    int base;
    int up_q[$];
    int dn_q[$];
    int exp4[6] = '{7, 27, 35, 43, 51, 59};
    int exp6[3] = '{7, 27, 39};

    always #5 clk = ~clk;

    boton_pulso_repeticion #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .CNT_W          (26)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up_raw  (btn_up_raw),
        .btn_down_raw(btn_down_raw),
        .aumento     (aumento),
        .disminuye   (disminuye),
        .up_level    (up_level),
        .down_level  (down_level)
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Advance n edges, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (aumento) up_q.push_back(edge_n);
            if (disminuye) dn_q.push_back(edge_n);
            check("mutex", int'(aumento & disminuye), 0);
        end
    endtask

    task automatic clear_q();
        up_q.delete();
        dn_q.delete();
    endtask

    initial begin
        rst          = 1'b1;
        btn_up_raw   = 1'b1;
        btn_down_raw = 1'b0;

        // 1. Reset held with up pressed, then re-debounce
        step(3);
        check("rst_aumento", int'(aumento), 0);
        check("rst_disminuye", int'(disminuye), 0);
        check("rst_up_level", int'(up_level), 0);
        check("rst_down_level", int'(down_level), 0);
        rst  = 1'b0;
        base = edge_n;
        clear_q();
        step(5);
        check("s1_up_level_e5", int'(up_level), 0);
        check("s1_aumento_e5", int'(aumento), 0);
        step(1);
        check("s1_up_level_e6", int'(up_level), 1);
        step(1);
        check("s1_aumento_e7", int'(aumento), 1);
        step(1);
        check("s1_aumento_e8", int'(aumento), 0);
        btn_up_raw = 1'b0;
        step(12);
        check("s1_up_count", up_q.size(), 1);
        check("s1_up_edge", at(up_q, 0), base + 7);
        check("s1_dn_count", dn_q.size(), 0);

        // 2. Clean tap
        base = edge_n;
        clear_q();
        btn_up_raw = 1'b1;
        step(10);
        btn_up_raw = 1'b0;
        step(5);
        check("s2_up_level_hold", int'(up_level), 1);
        step(1);
        check("s2_up_level_rel", int'(up_level), 0);
        step(4);
        check("s2_up_count", up_q.size(), 1);
        check("s2_up_edge", at(up_q, 0), base + 7);
        check("s2_dn_count", dn_q.size(), 0);

        // 3. Bouncing down button, then stable
        base = edge_n;
        clear_q();
        for (int k = 0; k < 12; k++) begin
            btn_down_raw = ((k / 2) % 2) == 0;
            step(1);
        end
        check("s3_down_level_bounce", int'(down_level), 0);
        check("s3_dn_none_bounce", dn_q.size(), 0);
        btn_down_raw = 1'b1;
        step(6);
        check("s3_down_level_stable", int'(down_level), 1);
        btn_down_raw = 1'b0;
        step(12);
        check("s3_dn_count", dn_q.size(), 1);
        check("s3_dn_edge", at(dn_q, 0), base + 19);
        check("s3_up_count", up_q.size(), 0);

        // 4. Hold and auto-repeat
        base = edge_n;
        clear_q();
        btn_up_raw = 1'b1;
        step(60);
        btn_up_raw = 1'b0;
        step(12);
        check("s4_up_count", up_q.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("s4_up_edge%0d", i), at(up_q, i), base + exp4[i]);
        check("s4_dn_count", dn_q.size(), 0);

        // 5. Both pressed: outputs suppressed, no pulse on release of the other
        base = edge_n;
        clear_q();
        btn_up_raw = 1'b1;
        step(10);
        btn_down_raw = 1'b1;
        step(20);
        check("s5_up_level_both", int'(up_level), 1);
        check("s5_down_level_both", int'(down_level), 1);
        btn_down_raw = 1'b0;
        step(20);
        check("s5_down_level_rel", int'(down_level), 0);
        check("s5_up_count_mid", up_q.size(), 1);
        btn_up_raw = 1'b0;
        step(10);
        btn_up_raw = 1'b1;
        step(10);
        btn_up_raw = 1'b0;
        step(12);
        check("s5_up_count", up_q.size(), 2);
        check("s5_up_edge0", at(up_q, 0), base + 7);
        check("s5_up_edge1", at(up_q, 1), base + 67);
        check("s5_dn_count", dn_q.size(), 0);

        // 6. Reset in the middle of repeat
        base = edge_n;
        clear_q();
        btn_up_raw = 1'b1;
        step(31);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("s6_up_level_rst", int'(up_level), 0);
        check("s6_aumento_rst", int'(aumento), 0);
        step(8);
        btn_up_raw = 1'b0;
        step(12);
        check("s6_up_count", up_q.size(), 3);
        for (int i = 0; i < 3; i++) check($sformatf("s6_up_edge%0d", i), at(up_q, i), base + exp6[i]);
        check("s6_dn_count", dn_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
